// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the program loader: FSM state encoding, byte/word
// geometry helpers and the byte-lane index width.
// -----------------------------------------------------------------------------
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int BYTE_W = 8;

  // Geometry helpers so modules with a non-default WIDTH stay consistent.
  function automatic int bytes_per_word(input int width);
    return width / BYTE_W;
  endfunction

  function automatic int lane_idx_width(input int width);
    int n_bytes;
    n_bytes = width / BYTE_W;
    return (n_bytes > 1) ? $clog2(n_bytes) : 1;
  endfunction

  // Values for the default 32-bit instruction word.
  localparam int BYTES_PER_WORD = bytes_per_word(32);
  localparam int LANE_IDX_W     = lane_idx_width(32);

endpackage

// File: rtl/word_assembler.sv
// -----------------------------------------------------------------------------
// word_assembler
// Collects bytes into one little-endian word: byte k of the word lands in
// lane [8k+7:8k]. A clear empties the word (all lanes zero) and rewinds the
// lane index, so a partially filled word reads back with zero upper lanes.
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-low reset
//   i_clear   empty the word and rewind the lane index (wins over i_accept)
//   i_accept  insert i_byte at the current lane and advance the index
//   i_byte    byte to insert
//   o_word    assembled word
//   o_last    current lane is the top lane of the word
//   o_empty   no byte collected yet
// -----------------------------------------------------------------------------
module word_assembler
  import loader_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_accept,
  input  logic [7:0]       i_byte,
  output logic [WIDTH-1:0] o_word,
  output logic             o_last,
  output logic             o_empty
);

  localparam int BPW   = bytes_per_word(WIDTH);
  localparam int IDX_W = lane_idx_width(WIDTH);

  logic [WIDTH-1:0] r_word;
  logic [IDX_W-1:0] r_idx;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its inputs regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_word <= '0;
      r_idx  <= '0;
    end else if (i_clear) begin
      r_word <= '0;
      r_idx  <= '0;
    end else if (i_accept) begin
      r_word[BYTE_W*r_idx +: BYTE_W] <= i_byte;
      r_idx                          <= r_idx + 1'b1;
    end
  end

  assign o_word  = r_word;
  assign o_last  = (r_idx == IDX_W'(BPW - 1));
  assign o_empty = (r_idx == '0);

endmodule

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
// Feeds the RISC-V core's program memory from a narrow byte stream. Bytes are
// assembled into little-endian words and written to consecutive addresses
// starting at 0. The core is held in reset while a load is running and is
// released when the load completes.
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-low reset
//   load_en     load window; a new load starts on its level from IDLE or on
//               a rising edge from DONE
//   byte_in     program byte, least-significant byte of each word first
//   byte_valid  byte_in valid this cycle
//   byte_ready  loader can accept a byte (LOAD state only)
//   mem_wen     program memory write strobe, one cycle per word
//   mem_wadd    program memory write address
//   mem_wdata   program memory write data
//   cpu_hold    core held in reset while a load is in progress
//   done        load complete; sticky until the next load starts
//   word_count  words written in the current or last load
// -----------------------------------------------------------------------------
module program_loader
  import loader_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ADD_WIDTH = 8,
  parameter int DEPTH     = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_en,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  output logic                 mem_wen,
  output logic [ADD_WIDTH-1:0] mem_wadd,
  output logic [WIDTH-1:0]     mem_wdata,
  output logic                 cpu_hold,
  output logic                 done,
  output logic [ADD_WIDTH:0]   word_count
);

  localparam logic [ADD_WIDTH-1:0] LAST_ADDR = ADD_WIDTH'(DEPTH - 1);

  state_e                 r_state;
  state_e                 w_next_state;
  logic [ADD_WIDTH-1:0]   r_addr;
  logic [ADD_WIDTH:0]     r_word_count;
  logic                   r_load_en_q;

  logic                   w_byte_ready;
  logic                   w_accept;
  logic                   w_start;
  logic                   w_in_write;
  logic                   w_clear;
  logic                   w_last;
  logic                   w_empty;
  logic [WIDTH-1:0]       w_word;

  assign w_byte_ready = (r_state == LOAD);
  assign w_accept     = byte_valid & w_byte_ready & load_en;
  assign w_in_write   = (r_state == WRITE);

  // From DONE only a fresh 0->1 edge restarts, so a load_en level held over
  // from the finished load cannot immediately overwrite the program.
  assign w_start = ((r_state == IDLE) & load_en) |
                   ((r_state == DONE) & load_en & ~r_load_en_q);

  // The word is emptied when it has been written and when a load begins, so
  // a trailing partial word always carries zero upper lanes.
  assign w_clear = w_start | w_in_write;

  word_assembler #(
    .WIDTH (WIDTH)
  ) u_word_assembler (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_clear),
    .i_accept (w_accept),
    .i_byte   (byte_in),
    .o_word   (w_word),
    .o_last   (w_last),
    .o_empty  (w_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: the default assignment at the top keeps every path assigned, so no
  // latch is inferred for w_next_state.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: begin
        if (load_en) w_next_state = LOAD;
      end
      LOAD: begin
        if (!load_en) begin
          w_next_state = w_empty ? DONE : WRITE;
        end else if (w_accept && w_last) begin
          w_next_state = WRITE;
        end
      end
      WRITE: begin
        // The top address always ends the load; the address never wraps.
        if ((r_addr == LAST_ADDR) || !load_en) begin
          w_next_state = DONE;
        end else begin
          w_next_state = LOAD;
        end
      end
      DONE: begin
        if (w_start) w_next_state = LOAD;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr       <= '0;
      r_word_count <= '0;
      r_load_en_q  <= 1'b0;
    end else begin
      r_load_en_q <= load_en;
      if (w_start) begin
        r_addr       <= '0;
        r_word_count <= '0;
      end else if (w_in_write) begin
        r_word_count <= r_word_count + 1'b1;
        if (w_next_state == LOAD) r_addr <= r_addr + 1'b1;
      end
    end
  end

  assign byte_ready = w_byte_ready;
  assign mem_wen    = w_in_write;
  assign mem_wadd   = r_addr;
  assign mem_wdata  = w_word;
  assign cpu_hold   = (r_state == LOAD) | (r_state == WRITE);
  assign done       = (r_state == DONE);
  assign word_count = r_word_count;

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
// Self-checking bench for program_loader. Each load records the bytes sent;
// the reference model turns that byte list into the expected sequence of
// (address, word) writes by chunking into little-endian words, zero-filling
// the last partial word and capping at DEPTH words. A monitor collects the
// writes the DUT actually makes and the two lists are compared.
// -----------------------------------------------------------------------------
module tb_program_loader;

  localparam int WIDTH     = 32;
  localparam int ADD_WIDTH = 8;
  localparam int DEPTH     = 256;
  localparam int BPW       = WIDTH / 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 load_en = 1'b0;
  logic [7:0]           byte_in = 8'h00;
  logic                 byte_valid = 1'b0;
  logic                 byte_ready;
  logic                 mem_wen;
  logic [ADD_WIDTH-1:0] mem_wadd;
  logic [WIDTH-1:0]     mem_wdata;
  logic                 cpu_hold;
  logic                 done;
  logic [ADD_WIDTH:0]   word_count;

  typedef struct packed {
    logic [ADD_WIDTH-1:0] addr;
    logic [WIDTH-1:0]     data;
  } wr_t;

  wr_t        got_q[$];
  wr_t        exp_q[$];
  logic [7:0] tx_q[$];
  wr_t        mon_w;

  int n_checks = 0;
  int n_errors = 0;

  program_loader #(
    .WIDTH     (WIDTH),
    .ADD_WIDTH (ADD_WIDTH),
    .DEPTH     (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_en    (load_en),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .mem_wen    (mem_wen),
    .mem_wadd   (mem_wadd),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst && mem_wen === 1'b1) begin
      mon_w.addr = mem_wadd;
      mon_w.data = mem_wdata;
      got_q.push_back(mon_w);
      check("ready_in_write", {63'd0, byte_ready}, 64'd0);
      check("hold_in_write", {63'd0, cpu_hold}, 64'd1);
    end
  end

  // Reference model: bytes -> expected write list.
  task automatic build_expected();
    int  nwords;
    int  k;
    wr_t w;
    exp_q.delete();
    nwords = (tx_q.size() + BPW - 1) / BPW;
    if (nwords > DEPTH) nwords = DEPTH;
    for (int i = 0; i < nwords; i++) begin
      w.addr = ADD_WIDTH'(i);
      w.data = '0;
      for (int b = 0; b < BPW; b++) begin
        k = i * BPW + b;
        if (k < tx_q.size()) w.data[8*b +: 8] = tx_q[k];
      end
      exp_q.push_back(w);
    end
  endtask

  task automatic compare_writes(input string tag);
    int n;
    build_expected();
    check({tag, "_nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_addr"}, 64'(got_q[i].addr), 64'(exp_q[i].addr));
      check({tag, "_data"}, 64'(got_q[i].data), 64'(exp_q[i].data));
    end
    check({tag, "_word_count"}, 64'(word_count), 64'(exp_q.size()));
    check({tag, "_done"}, {63'd0, done}, 64'd1);
    check({tag, "_hold"}, {63'd0, cpu_hold}, 64'd0);
  endtask

  // Called at posedge+1; returns at posedge+1 with the DUT in its first LOAD cycle.
  task automatic start_load(input string tag);
    load_en = 1'b0;
    got_q.delete();
    tx_q.delete();
    @(posedge clk);
    #1 load_en = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_hold_first_load"}, {63'd0, cpu_hold}, 64'd1);
    check({tag, "_done_cleared"}, {63'd0, done}, 64'd0);
    check({tag, "_ready_in_load"}, {63'd0, byte_ready}, 64'd1);
    check({tag, "_count_init"}, 64'(word_count), 64'd0);
  endtask

  // Offers one byte after 'gap' idle cycles; returns at posedge+1 after acceptance.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    byte_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    byte_in    = b;
    byte_valid = 1'b1;
    tx_q.push_back(b);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (byte_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("ready_timeout", {63'd0, byte_ready}, 64'd1);
    @(posedge clk);
    #1 byte_valid = 1'b0;
  endtask

  task automatic end_load();
    bit ok;
    load_en = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("done_timeout", {63'd0, done}, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_byte_ready"}, {63'd0, byte_ready}, 64'd0);
    check({tag, "_mem_wen"}, {63'd0, mem_wen}, 64'd0);
    check({tag, "_mem_wadd"}, 64'(mem_wadd), 64'd0);
    check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    check({tag, "_cpu_hold"}, {63'd0, cpu_hold}, 64'd0);
    check({tag, "_done"}, {63'd0, done}, 64'd0);
    check({tag, "_word_count"}, 64'(word_count), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         n_before;
    int         ready_seen;
    int         len;
    logic [7:0] first_four[4];

    // Reset state.
    #3;
    check_reset_values("reset");
    @(posedge clk);
    #1 rst = 1'b1;

    // Single word 13 00 50 00.
    first_four[0] = 8'h13;
    first_four[1] = 8'h00;
    first_four[2] = 8'h50;
    first_four[3] = 8'h00;
    start_load("one");
    for (int i = 0; i < 4; i++) send_byte(first_four[i], 0);
    check("one_wen", {63'd0, mem_wen}, 64'd1);
    check("one_ready_write", {63'd0, byte_ready}, 64'd0);
    check("one_wadd", 64'(mem_wadd), 64'd0);
    check("one_wdata", 64'(mem_wdata), 64'h00500013);
    end_load();
    compare_writes("one");

    // Three words then load_en dropped.
    start_load("three");
    for (int i = 0; i < 3 * BPW; i++) send_byte(8'($urandom), 0);
    end_load();
    compare_writes("three");

    // Partial word AA BB.
    start_load("part");
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    end_load();
    compare_writes("part");
    if (got_q.size() > 0) check("part_wdata", 64'(got_q[0].data), 64'h0000BBAA);

    // Restart from DONE: address and count start over.
    start_load("restart");
    for (int i = 0; i < BPW; i++) send_byte(8'($urandom), 0);
    end_load();
    compare_writes("restart");

    // Reset mid-word after two bytes.
    start_load("rst_mid");
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    #2 rst = 1'b0;
    #1;
    check_reset_values("rst_mid");
    check("rst_mid_no_write", 64'(got_q.size()), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    start_load("after_rst");
    for (int i = 0; i < BPW; i++) send_byte(8'($urandom), 0);
    end_load();
    compare_writes("after_rst");

    // Randomized loads with random lengths and byte gaps.
    for (int t = 0; t < 6; t++) begin
      start_load("rnd");
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) send_byte(8'($urandom), $urandom_range(0, 2));
      end_load();
      compare_writes("rnd");
    end

    // Fill all of memory with load_en held; the top address ends the load.
    start_load("full");
    for (int i = 0; i < DEPTH * BPW; i++) send_byte(8'($urandom), 0);
    check("full_last_wadd", 64'(mem_wadd), 64'(DEPTH - 1));
    n_before   = got_q.size() + 1;  // the final write is sampled this cycle
    ready_seen = 0;
    byte_in    = 8'h5A;
    byte_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (byte_ready) ready_seen++;
    end
    byte_valid = 1'b0;
    check("full_ready_after", 64'(ready_seen), 64'd0);
    check("full_no_extra_writes", 64'(got_q.size()), 64'(n_before));
    compare_writes("full");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Upstream feeder for the program memory of the pipelined RISC-V core. It accepts a byte stream over a narrow valid/ready interface (Tiny Tapeout pin budget) and assembles 32-bit little-endian instruction words. It writes those words sequentially into the program memory write port. It holds the CPU in reset while a load is in progress and releases it when the load completes.

Parameters:
- WIDTH, 32, instruction word width; must be a multiple of 8.
- ADD_WIDTH, 8, program memory address width.
- DEPTH, 256, number of program memory words; the last address is DEPTH-1.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  asynchronous, active-low reset.
- load_en  input  1  load window; high = loading requested.
- byte_in  input  8  program byte, least-significant byte of each word first.
- byte_valid  input  1  byte_in valid this cycle.
- byte_ready  output  1  loader can accept a byte this cycle.
- mem_wen  output  1  program memory write strobe, one cycle per word.
- mem_wadd  output  ADD_WIDTH  program memory write address.
- mem_wdata  output  WIDTH  program memory write data.
- cpu_hold  output  1  high = CPU core held in reset.
- done  output  1  load complete; sticky until the next load starts.
- word_count  output  ADD_WIDTH+1  number of words written in the current or last load.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE.
  - byte_ready = 0, mem_wen = 0, mem_wadd = 0, mem_wdata = 0.
  - cpu_hold = 0, done = 0, word_count = 0.
  - The internal byte index and the assembly register are cleared.
- States: IDLE, LOAD, WRITE, DONE.
- IDLE:
  - byte_ready = 0.
  - When load_en = 1, go to LOAD. In the same transition: cpu_hold = 1, write address = 0, word_count = 0, byte index = 0, done = 0.
- LOAD:
  - byte_ready = 1.
  - A byte is accepted when byte_valid & byte_ready & load_en. It is placed in lane [8*idx+7 : 8*idx] and idx increments.
  - On acceptance of byte WIDTH/8-1 in cycle N: go to WRITE. In cycle N+1: mem_wen = 1, mem_wadd = current address, mem_wdata = the full word.
  - If load_en falls while idx != 0: go to WRITE. The partial word is written with unfilled upper lanes = 0.
  - If load_en falls while idx = 0: go to DONE with no write.
  - byte_valid while load_en = 0 is ignored.
- WRITE (exactly one cycle):
  - byte_ready = 0, mem_wen = 1.
  - word_count increments and idx clears.
  - If mem_wadd = DEPTH-1 or load_en = 0: go to DONE.
  - Otherwise: address increments and the state returns to LOAD.
- DONE:
  - cpu_hold = 0, done = 1, byte_ready = 0, mem_wen = 0.
  - Bytes are ignored.
  - A 0->1 edge of load_en (registered previous value) starts a new load: go to LOAD, with the same initialisation as from IDLE.
  - A level-high load_en held over from the previous load does not restart.
- Address never wraps. Writing address DEPTH-1 always terminates the load.
- mem_wen is never asserted outside WRITE. mem_wadd and mem_wdata are stable for the whole WRITE cycle.
- Reset mid-load: immediate return to IDLE and the CPU is released. Memory contents already written are left untouched.
- Throughput: a new word every WIDTH/8+1 cycles with byte_valid held high.

Decomposition:
- Shared package loader_pkg holds:
  - the state encoding: IDLE = 2'd0, LOAD = 2'd1, WRITE = 2'd2, DONE = 2'd3;
  - BYTES_PER_WORD = WIDTH/8;
  - the lane index width.
- One sub-module is natural: word_assembler, a byte-lane shift/insert register with byte index, clear and zero-fill.
- The FSM and address counter stay in program_loader.

Test Plan:
- Reset then load_en = 1 and bytes 13,00,50,00 back-to-back. Required:
  - one write at mem_wadd = 0 with mem_wdata = 32'h00500013;
  - cpu_hold high from the first LOAD cycle;
  - byte_ready low in the WRITE cycle.
- Three words streamed, then load_en dropped. Required:
  - writes at addresses 0, 1, 2;
  - word_count = 3, done = 1, cpu_hold = 0 on the cycle after the last WRITE.
- Two bytes AA, BB then load_en low. Required:
  - one write with mem_wdata = 32'h0000BBAA;
  - the state then moves to DONE.
- 256 full words streamed with load_en held. Required:
  - last write at mem_wadd = 255;
  - word_count = 256, done = 1;
  - further bytes see byte_ready = 0 and produce no writes.
- rst pulsed low mid-word after 2 bytes. Required:
  - all outputs return to reset values asynchronously;
  - no mem_wen pulse is generated;
  - a fresh load then starts at address 0.
- In DONE, load_en toggled 0->1 and 4 bytes sent. Required:
  - done clears, cpu_hold reasserts;
  - the write lands at address 0 with word_count = 1.
